// File: rtl/tdm_demux_8ch.sv
// Receive side of the slot-serial TDM link: rebuilds NUM_CH-slot frames from a
// sample stream, checks alignment and hands complete frames out over valid/ready.
module tdm_demux_8ch #(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3,
    parameter int DATA_W = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       din_valid_i,
    input  logic [DATA_W-1:0]          din_i,
    input  logic                       din_sof_i,
    output logic [SEL_W-1:0]           slot_o,
    output logic [NUM_CH*DATA_W-1:0]   frame_out_o,
    output logic                       frame_valid_o,
    input  logic                       frame_ready_i,
    output logic                       overrun_o,
    output logic                       sync_err_o
);

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);

    state_t                     state_q, state_d;
    logic [SEL_W-1:0]           slot_q, slot_d;
    logic [NUM_CH*DATA_W-1:0]   buf_q, buf_d;
    logic [NUM_CH*DATA_W-1:0]   frame_q, frame_d;
    logic                       valid_q, valid_d;
    logic                       overrun_q, overrun_d;
    logic                       sync_err_q, sync_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            slot_q     <= '0;
            buf_q      <= '0;
            frame_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            buf_q      <= buf_d;
            frame_q    <= frame_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            sync_err_q <= sync_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        buf_d      = buf_q;
        frame_d    = frame_q;
        valid_d    = valid_q && !frame_ready_i;
        overrun_d  = 1'b0;
        sync_err_d = 1'b0;

        if (din_valid_i) begin
            unique case (state_q)
                HUNT: begin
                    if (din_sof_i) begin
                        buf_d[0 +: DATA_W] = din_i;
                        slot_d             = SEL_W'(1);
                        state_d            = COLLECT;
                    end
                end
                COLLECT: begin
                    if (slot_q != '0 && din_sof_i) begin
                        // Realign on the unexpected sof; the partial frame is simply abandoned.
                        sync_err_d         = 1'b1;
                        buf_d[0 +: DATA_W] = din_i;
                        slot_d             = SEL_W'(1);
                    end else if (slot_q == '0 && !din_sof_i) begin
                        sync_err_d = 1'b1;
                        slot_d     = '0;
                        state_d    = HUNT;
                    end else begin
                        buf_d[slot_q*DATA_W +: DATA_W] = din_i;
                        if (slot_q == LAST_SLOT) begin
                            slot_d = '0;
                            if (!valid_q || frame_ready_i) begin
                                frame_d = buf_d;
                                valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            slot_d = slot_q + SEL_W'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign slot_o        = slot_q;
    assign frame_out_o   = frame_q;
    assign frame_valid_o = valid_q;
    assign overrun_o     = overrun_q;
    assign sync_err_o    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Scoreboard bench for tdm_demux_8ch: a queue-based frame model predicts frames
// and error pulses; a negedge monitor pops and compares against the DUT.
module tb_tdm_demux_8ch;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int DATA_W = 1;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      din_valid = 1'b0;
    logic [DATA_W-1:0]         din = '0;
    logic                      din_sof = 1'b0;
    logic [SEL_W-1:0]          slot;
    logic [NUM_CH*DATA_W-1:0]  frame_out;
    logic                      frame_valid;
    logic                      frame_ready = 1'b1;
    logic                      overrun;
    logic                      sync_err;

    int vectors = 0;
    int miscompares = 0;

    tdm_demux_8ch #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din_valid_i   (din_valid),
        .din_i         (din),
        .din_sof_i     (din_sof),
        .slot_o        (slot),
        .frame_out_o   (frame_out),
        .frame_valid_o (frame_valid),
        .frame_ready_i (frame_ready),
        .overrun_o     (overrun),
        .sync_err_o    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is just the list of samples gathered since the last sof.
    logic [DATA_W-1:0]          partial[$];
    bit                         hunting = 1'b1;
    bit                         out_full = 1'b0;
    logic [NUM_CH*DATA_W-1:0]   exp_frames[$];
    int                         exp_events[$];   // 1 = sync_err, 2 = overrun

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial.delete();
            exp_frames.delete();
            exp_events.delete();
            hunting  = 1'b1;
            out_full = 1'b0;
        end else begin
            bit loaded;
            loaded = 1'b0;
            if (din_valid) begin
                if (hunting) begin
                    if (din_sof) begin
                        partial.delete();
                        partial.push_back(din);
                        hunting = 1'b0;
                    end
                end else if (din_sof && partial.size() != 0) begin
                    exp_events.push_back(1);
                    partial.delete();
                    partial.push_back(din);
                end else if (!din_sof && partial.size() == 0) begin
                    exp_events.push_back(1);
                    hunting = 1'b1;
                end else begin
                    partial.push_back(din);
                    if (partial.size() == NUM_CH) begin
                        if (!out_full || frame_ready) begin
                            logic [NUM_CH*DATA_W-1:0] f;
                            f = '0;
                            for (int i = 0; i < NUM_CH; i++) f[i*DATA_W +: DATA_W] = partial[i];
                            exp_frames.push_back(f);
                            loaded = 1'b1;
                        end else begin
                            exp_events.push_back(2);
                        end
                        partial.delete();
                    end
                end
            end
            out_full = loaded ? 1'b1 : (out_full && !frame_ready);
        end
    end

    function automatic int model_slot();
        return hunting ? 0 : partial.size();
    endfunction

    // Monitor: everything is stable at the falling edge.
    always @(negedge clk) begin
        check("slot", 64'(slot), 64'(model_slot()));
        check("frame_valid", 64'(frame_valid), 64'(out_full));
        if (frame_valid && frame_ready) begin
            if (exp_frames.size() == 0) check("unexpected_frame", 64'(frame_out), 64'hDEAD);
            else check("frame_out", 64'(frame_out), 64'(exp_frames.pop_front()));
        end
        if (sync_err || overrun) begin
            if (exp_events.size() == 0) check("unexpected_pulse", 64'({overrun, sync_err}), 64'd0);
            else check("pulse_kind", 64'({overrun, sync_err}), 64'(exp_events.pop_front()));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input logic [DATA_W-1:0] d, input logic s);
        din_valid = 1'b1;
        din       = d;
        din_sof   = s;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] v, input int max_gap);
        for (int k = 0; k < NUM_CH; k++) begin
            if (max_gap > 0) idle($urandom_range(max_gap, 0));
            sample(v[k], k == 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle(2);
        check("rst_frame_out", 64'(frame_out), 64'h0);
        rst_n = 1'b1;
        idle(1);

        // Single frame, valid one clock after the last sample.
        send_frame(8'hAB, 0);
        check("t1_frame_out", 64'(frame_out), 64'hAB);
        check("t1_valid", 64'(frame_valid), 64'd1);
        idle(2);

        // Back-to-back frames with ready high.
        send_frame(8'hAB, 0);
        send_frame(8'h5C, 0);
        check("t2_frame_out", 64'(frame_out), 64'h5C);
        idle(2);

        // Output held: second frame overruns, first stays put.
        frame_ready = 1'b0;
        send_frame(8'hAB, 0);
        send_frame(8'h5C, 0);
        check("t3_overrun", 64'(overrun), 64'd1);
        check("t3_frame_out", 64'(frame_out), 64'hAB);
        frame_ready = 1'b1;
        idle(1);
        check("t3_valid_drop", 64'(frame_valid), 64'd0);

        // Mid-frame sof at slot 4 starts the next frame.
        for (int k = 0; k < 4; k++) sample(1'b1, k == 0);
        send_frame(8'h0F, 0);
        check("t4_frame_out", 64'(frame_out), 64'h0F);
        idle(2);

        // Gapped samples.
        send_frame(8'h96, 3);
        check("t5_frame_out", 64'(frame_out), 64'h96);
        idle(2);

        // Reset in the middle of a frame.
        for (int k = 0; k < 5; k++) sample(1'b1, k == 0);
        rst_n = 1'b0;
        #1;
        check("t6_slot", 64'(slot), 64'd0);
        check("t6_frame_out", 64'(frame_out), 64'h0);
        check("t6_pulses", 64'({frame_valid, overrun, sync_err}), 64'd0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        send_frame(8'h3C, 0);
        check("t6_frame_out2", 64'(frame_out), 64'h3C);
        idle(2);

        // Slot-0 sample without sof drops back to hunting.
        send_frame(8'h81, 0);
        sample(1'b1, 1'b0);
        check("t7_sync_err", 64'(sync_err), 64'd1);
        for (int k = 0; k < 5; k++) sample(1'b0, 1'b0);
        check("t7_hunt_slot", 64'(slot), 64'd0);
        send_frame(8'h42, 1);
        check("t7_frame_out", 64'(frame_out), 64'h42);

        // Random traffic: mostly well-framed, occasional misalignment, stalls and resets.
        for (int n = 0; n < 3000; n++) begin
            frame_ready = ($urandom_range(9, 0) < 7);
            if ($urandom_range(399, 0) == 0) begin
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
            end else if ($urandom_range(3, 0) == 0) begin
                idle(1);
            end else begin
                logic s;
                s = (model_slot() == 0);
                if ($urandom_range(19, 0) == 0) s = ~s;
                sample(DATA_W'($urandom), s);
            end
        end

        frame_ready = 1'b1;
        idle(4);
        check("drain_frames", 64'(exp_frames.size()), 64'd0);
        check("drain_events", 64'(exp_events.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
